// File: rtl/alarm_controller.sv
// Alarm controller: compares BCD time-of-day against an HH:MM alarm and runs
// the ring / snooze / stop state machine, paced by the shared 1 Hz tick.
module alarm_controller #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic [2:0] S1,
  input  logic [3:0] S2,
  input  logic [1:0] AH1,
  input  logic [3:0] AH2,
  input  logic [2:0] AM1,
  input  logic [3:0] AM2,
  input  logic       alarm_en,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       ringing,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt
);

  localparam int unsigned RW = $clog2(RING_SECS + 1);
  localparam int unsigned SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_match_q;
  logic [RW-1:0] r_ring_cnt;
  logic [SW-1:0] r_snz_cnt;
  logic [1:0]    r_snooze_cnt;
  logic          r_buzzer;
  logic          r_ringing;
  logic          r_snooze_active;

  state_t        w_state_nxt;
  logic [RW-1:0] w_ring_nxt;
  logic [SW-1:0] w_snz_nxt;
  logic [1:0]    w_scnt_nxt;
  logic          w_buzz_nxt;
  logic          w_match;
  logic          w_trigger;

  assign w_match = alarm_en & (H1 == AH1) & (H2 == AH2) & (M1 == AM1) & (M2 == AM2)
                 & (S1 == 3'd0) & (S2 == 4'd0);
  // Rising edge only, so a match held through HH:MM:00 fires once.
  assign w_trigger = w_match & ~r_match_q;

  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;
    w_scnt_nxt  = r_snooze_cnt;
    w_buzz_nxt  = r_buzzer;
    if (!alarm_en) begin
      w_state_nxt = IDLE;
      w_buzz_nxt  = 1'b0;
      w_scnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_buzz_nxt = 1'b0;
          if (w_trigger) begin
            w_state_nxt = RINGING;
            w_ring_nxt  = '0;
            w_scnt_nxt  = '0;
            w_buzz_nxt  = 1'b1;
          end
        end
        RINGING: begin
          if (btn_stop) begin
            w_state_nxt = IDLE;
            w_buzz_nxt  = 1'b0;
            w_scnt_nxt  = '0;
          end else if (btn_snooze && (r_snooze_cnt < SNZ_MAX)) begin
            w_state_nxt = SNOOZE;
            w_snz_nxt   = '0;
            w_scnt_nxt  = r_snooze_cnt + 2'd1;
            w_buzz_nxt  = 1'b0;
          end else if (sec_tick) begin
            if (r_ring_cnt == RING_LAST) begin
              w_state_nxt = IDLE;
              w_buzz_nxt  = 1'b0;
              w_scnt_nxt  = '0;
            end else begin
              w_ring_nxt = r_ring_cnt + RW'(1);
              w_buzz_nxt = ~r_buzzer;
            end
          end
        end
        SNOOZE: begin
          w_buzz_nxt = 1'b0;
          if (btn_stop) begin
            w_state_nxt = IDLE;
            w_scnt_nxt  = '0;
          end else if (sec_tick) begin
            if (r_snz_cnt == SNZ_LAST) begin
              w_state_nxt = RINGING;
              w_ring_nxt  = '0;
              w_buzz_nxt  = 1'b1;
            end else begin
              w_snz_nxt = r_snz_cnt + SW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_buzz_nxt  = 1'b0;
          w_scnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_match_q       <= 1'b0;
      r_ring_cnt      <= '0;
      r_snz_cnt       <= '0;
      r_snooze_cnt    <= '0;
      r_buzzer        <= 1'b0;
      r_ringing       <= 1'b0;
      r_snooze_active <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_match_q       <= w_match;
      r_ring_cnt      <= w_ring_nxt;
      r_snz_cnt       <= w_snz_nxt;
      r_snooze_cnt    <= w_scnt_nxt;
      r_buzzer        <= w_buzz_nxt;
      r_ringing       <= (w_state_nxt == RINGING);
      r_snooze_active <= (w_state_nxt == SNOOZE);
    end
  end

  assign state         = r_state;
  assign ringing       = r_ringing;
  assign snooze_active = r_snooze_active;
  assign buzzer        = r_buzzer;
  assign snooze_cnt    = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random stimulus, checked
// against a seconds-of-day / phase-elapsed reference model.
module tb_alarm_controller;

  localparam int RING = 4;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sec_tick = 1'b0, alarm_en = 1'b0, btn_stop = 1'b0, btn_snooze = 1'b0;
  logic [1:0] H1, AH1;
  logic [3:0] H2, M2, S2, AH2, AM2;
  logic [2:0] M1, S1, AM1;
  logic ringing, buzzer, snooze_active;
  logic [1:0] state, snooze_cnt;

  int t   = 0;
  int a_h = 7;
  int a_m = 30;

  int m_mode = 0;
  int m_el   = 0;
  int m_snz  = 0;
  bit m_prev = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign H1  = 2'((t / 3600) / 10);
  assign H2  = 4'((t / 3600) % 10);
  assign M1  = 3'(((t / 60) % 60) / 10);
  assign M2  = 4'(((t / 60) % 60) % 10);
  assign S1  = 3'((t % 60) / 10);
  assign S2  = 4'((t % 60) % 10);
  assign AH1 = 2'(a_h / 10);
  assign AH2 = 4'(a_h % 10);
  assign AM1 = 3'(a_m / 10);
  assign AM2 = 4'(a_m % 10);

  alarm_controller #(
    .RING_SECS  (RING),
    .SNOOZE_SECS(SNZ),
    .MAX_SNOOZE (MAXS)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
    .alarm_en(alarm_en), .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .ringing(ringing), .buzzer(buzzer), .snooze_active(snooze_active),
    .state(state), .snooze_cnt(snooze_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " state"},         8'(state),         8'(m_mode));
    check({tag, " ringing"},       8'(ringing),       8'(m_mode == 1));
    check({tag, " snooze_active"}, 8'(snooze_active), 8'(m_mode == 2));
    check({tag, " buzzer"},        8'(buzzer),        8'(m_mode == 1 && (m_el % 2) == 0));
    check({tag, " snooze_cnt"},    8'(snooze_cnt),    8'(m_snz));
  endtask

  task automatic model_reset();
    m_mode = 0; m_el = 0; m_snz = 0; m_prev = 1'b0;
  endtask

  // Buzzer is implied: on at the start of each ring phase, flips every elapsed second.
  task automatic model_step();
    bit match, trig;
    match  = alarm_en && (t / 3600) == a_h && ((t / 60) % 60) == a_m && (t % 60) == 0;
    trig   = match && !m_prev;
    m_prev = match;
    if (!alarm_en) begin
      m_mode = 0; m_snz = 0;
    end else if (m_mode == 0) begin
      if (trig) begin m_mode = 1; m_el = 0; m_snz = 0; end
    end else if (m_mode == 1) begin
      if (btn_stop) begin m_mode = 0; m_snz = 0; end
      else if (btn_snooze && m_snz < MAXS) begin m_mode = 2; m_el = 0; m_snz++; end
      else if (sec_tick) begin
        if (m_el + 1 == RING) begin m_mode = 0; m_snz = 0; end
        else m_el++;
      end
    end else begin
      if (btn_stop) begin m_mode = 0; m_snz = 0; end
      else if (sec_tick) begin
        if (m_el + 1 == SNZ) begin m_mode = 1; m_el = 0; end
        else m_el++;
      end
    end
  endtask

  task automatic cycle(input bit tk, input bit st, input bit sn, input string tag);
    sec_tick = tk; btn_stop = st; btn_snooze = sn;
    @(posedge clk);
    model_step();
    #1;
    sec_tick = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0;
    if (tk) t = (t + 1) % 86400;
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic arm_and_ring(input int hh, input int mm, input string tag);
    a_h = hh; a_m = mm; alarm_en = 1'b1;
    t = (hh * 3600 + mm * 60 + 86400 - 1) % 86400;
    cycle(1'b0, 1'b0, 1'b0, tag);
    cycle(1'b1, 1'b0, 1'b0, tag);
    cycle(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic ring at 07:30, no retrigger while match persists, buzzer toggling, auto-off.
    arm_and_ring(7, 30, "ring0730");
    check("ring0730 entered", 8'(state), 8'd1);
    cycle(1'b0, 1'b0, 1'b0, "hold_match");
    cycle(1'b0, 1'b0, 1'b0, "hold_match");
    ticks(RING, "autooff");
    check("autooff idle", 8'(state), 8'd0);

    // Disabled alarm at the exact time stays idle.
    alarm_en = 1'b0;
    t = 7 * 3600 + 30 * 60;
    cycle(1'b0, 1'b0, 1'b0, "disabled");
    ticks(2, "disabled");

    // Snooze sequence up to the snooze limit, then stop.
    arm_and_ring(7, 30, "snz_ring");
    cycle(1'b0, 1'b0, 1'b1, "snooze1");
    ticks(SNZ, "snooze1_wait");
    cycle(1'b0, 1'b0, 1'b1, "snooze2");
    ticks(SNZ, "snooze2_wait");
    cycle(1'b0, 1'b0, 1'b1, "snooze_ignored");
    check("snooze_ignored state", 8'(state), 8'd1);
    cycle(1'b0, 1'b1, 1'b0, "stop");

    // Stop and snooze together.
    arm_and_ring(7, 30, "both_ring");
    cycle(1'b0, 1'b1, 1'b1, "stop_and_snooze");

    // Timeout tick together with snooze, then alarm_en drop in snooze.
    arm_and_ring(7, 30, "to_ring");
    ticks(RING - 1, "to_wait");
    cycle(1'b1, 1'b0, 1'b1, "timeout_snooze");
    ticks(1, "in_snooze");
    alarm_en = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "en_drop");

    // Asynchronous reset in the middle of ringing.
    arm_and_ring(7, 30, "rst_ring");
    ticks(1, "rst_ring");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    t = 7 * 3600 + 30 * 60 + 5;
    @(posedge clk); #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, "rst_released");
    ticks(1, "rst_released");

    // Midnight rollover.
    arm_and_ring(0, 0, "midnight");
    check("midnight ring", 8'(state), 8'd1);
    cycle(1'b0, 1'b1, 1'b0, "midnight_stop");

    // Randomized traffic around the alarm time.
    alarm_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit tk, st, sn;
      if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 399) == 0) begin
        a_h = int'($urandom_range(0, 23));
        a_m = int'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 149) == 0)
        t = (a_h * 3600 + a_m * 60 + 86400 - int'($urandom_range(1, 3))) % 86400;
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 39) == 0);
      sn = ($urandom_range(0, 9) == 0);
      cycle(tk, st, sn, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the time-of-day counter's BCD digit outputs (H1/H2/M1/M2/S1/S2).
- Compares the running time against a user-set alarm time (HH:MM) and runs the ring/snooze/stop state machine.
- Drives the alarm LED and buzzer outputs.
- Timing is based on the same 1 Hz enable pulse that advances the time counter.

Parameters:
- RING_SECS, 60: seconds RINGING lasts before auto-off.
- SNOOZE_SECS, 300: seconds spent in SNOOZE before re-ringing.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-cycle pulse per second, same pulse that increments S2
- H1 in 2, H2 in 4, M1 in 3, M2 in 4, S1 in 3, S2 in 4  current time, BCD digits
- AH1 in 2, AH2 in 4, AM1 in 3, AM2 in 4  alarm time, BCD digits
- alarm_en  in  1  level; alarm armed
- btn_stop  in  1  one-cycle debounced pulse
- btn_snooze  in  1  one-cycle debounced pulse
- ringing  out  1  high in RINGING
- buzzer  out  1  square wave while RINGING
- snooze_active  out  1  high in SNOOZE
- state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE (11 unused)
- snooze_cnt  out  2  snoozes used in current event

Behaviour:
- Reset (rst=0, async): state=IDLE, ringing=0, buzzer=0, snooze_active=0, snooze_cnt=0, all internal counters=0, match_q=0.
- match (combinational) = alarm_en & H1==AH1 & H2==AH2 & M1==AM1 & M2==AM2 & S1==0 & S2==0.
  - match_q is match registered each clk.
  - trigger = match & ~match_q.
- All outputs are registered. ringing/snooze_active/state follow the state register.
- IDLE:
  - trigger -> RINGING next edge; latency 1 clk after digits reach HH:MM:00.
  - On entry to RINGING from IDLE: ring_cnt=0, snooze_cnt=0, buzzer=1.
- RINGING:
  - Each sec_tick: ring_cnt++ and buzzer toggles.
  - On the sec_tick where ring_cnt==RING_SECS-1: -> IDLE, buzzer=0.
  - btn_stop -> IDLE, buzzer=0.
  - btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE: snz_cnt=0, snooze_cnt++, buzzer=0.
  - btn_snooze with snooze_cnt==MAX_SNOOZE: ignored, stays RINGING.
- SNOOZE:
  - Each sec_tick: snz_cnt++.
  - On the sec_tick where snz_cnt==SNOOZE_SECS-1: -> RINGING, ring_cnt=0, buzzer=1; snooze_cnt kept.
  - btn_stop -> IDLE, snooze_cnt=0.
  - btn_snooze: ignored.
- Priority, highest first:
  1. alarm_en=0 forces IDLE from any state: buzzer=0, snooze_cnt=0.
  2. btn_stop.
  3. btn_snooze.
  4. Timeout.
- Simultaneous stop+snooze -> IDLE.
- Timeout and btn_stop in the same cycle -> IDLE.
- trigger while RINGING/SNOOZE: ignored (no counter restart).
- Counter widths:
  - ring_cnt: clog2(RING_SECS+1) bits.
  - snz_cnt: clog2(SNOOZE_SECS+1) bits.
  - No wrap occurs; both counters are cleared on state entry.
- sec_tick outside RINGING/SNOOZE has no effect.
- Time-counter rollover (23:59:59 -> 00:00:00) matches alarm 00:00 normally.
- Alarm digits are sampled live. Changing them while RINGING does not affect state.
- The state register never holds 11. If it does, the next edge goes to IDLE.

Test Plan:
- Reset mid-RINGING: assert rst=0 asynchronously -> ringing=0, buzzer=0, state=00 before the next clk edge; stays IDLE after release.
- Alarm 07:30, alarm_en=1, time steps 07:29:59 -> 07:30:00 -> state=01, ringing=1, buzzer=1 one clk later. The match persisting through 07:30:00 causes no retrigger. Buzzer toggles each sec_tick.
- Auto-off: RING_SECS=4, no buttons -> after 4 sec_ticks state=00, buzzer=0. Time 07:30:00 with alarm_en=0 -> stays IDLE.
- Snooze sequence: SNOOZE_SECS=3, MAX_SNOOZE=2.
  - btn_snooze -> state=10, snooze_cnt=1; after 3 sec_ticks -> state=01.
  - Snooze again -> snooze_cnt=2; after re-ring, btn_snooze is ignored (state stays 01).
  - btn_stop -> 00, snooze_cnt=0.
- Simultaneous events:
  - btn_stop & btn_snooze same cycle in RINGING -> IDLE.
  - Timeout sec_tick & btn_snooze same cycle -> SNOOZE.
  - alarm_en drop during SNOOZE -> IDLE, snooze_active=0.
- Midnight: alarm 00:00, time 23:59:59 -> 00:00:00 -> RINGING one clk later.
